// File: rtl/clip_distortion_multi.sv
// Multi-mode clipping stage: one frame of LANES signed samples per handshake,
// clipped in bypass/hard/soft-knee/asymmetric mode, with per-frame clip statistics.
module clip_distortion_multi #(
    parameter int                  SAMPLE_W   = 16,
    parameter int                  LANES      = 32,
    parameter int                  ADDR_W     = 32,
    parameter logic [SAMPLE_W-1:0] STEP       = 16'h0888,
    parameter int                  KNEE_SHIFT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           prev_module_done,
    output logic                           ready_for_data,
    input  logic [ADDR_W-1:0]              address_in,
    input  logic [LANES*SAMPLE_W-1:0]      audio_in,
    input  logic                           en,
    input  logic                           set_config,
    input  logic [3:0]                     magnitude,
    input  logic [1:0]                     mode,
    input  logic                           next_module_ready,
    output logic                           done,
    output logic [ADDR_W-1:0]              address_out,
    output logic [LANES*SAMPLE_W-1:0]      audio_out,
    output logic [$clog2(LANES+1)-1:0]     clip_count,
    output logic                           clip_sticky,
    output logic [1:0]                     dbg_state_o
);

    localparam int FW = LANES * SAMPLE_W;
    localparam int CW = $clog2(LANES + 1);
    localparam int TW = SAMPLE_W + 4;
    localparam int XW = SAMPLE_W + 2;
    localparam logic signed [XW-1:0] MAX_S = {3'b000, {(SAMPLE_W-1){1'b1}}};

    // Handshake: a frame is accepted on a rising edge where ready_for_data and
    // prev_module_done are both high; it is handed off on a rising edge where
    // done and next_module_ready are both high. done holds outputs stable until then.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROC   = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [3:0]        cfg_mag_q, cfg_mag_d;
    logic [1:0]        cfg_mode_q, cfg_mode_d;
    logic [3:0]        snap_mag_q, snap_mag_d;
    logic [1:0]        snap_mode_q, snap_mode_d;
    logic              snap_en_q, snap_en_d;
    logic [FW-1:0]     in_audio_q, in_audio_d;
    logic [ADDR_W-1:0] in_addr_q, in_addr_d;
    logic [FW-1:0]     out_audio_q, out_audio_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              sticky_q, sticky_d;

    logic              accept;
    logic              load_out;
    logic [TW-1:0]     t_raw;
    logic [SAMPLE_W-1:0] thr;
    logic [1:0]        eff_mode;
    logic [FW-1:0]     lane_y;
    logic [CW-1:0]     lane_cnt;

    function automatic logic [SAMPLE_W-1:0] clip_lane(
        input logic [SAMPLE_W-1:0] x,
        input logic [SAMPLE_W-1:0] t,
        input logic [1:0]          md
    );
        logic signed [XW-1:0] xs, ts, nt, e, y;
        xs = {{2{x[SAMPLE_W-1]}}, x};
        ts = {2'b00, t};
        nt = -ts;
        e  = '0;
        y  = xs;
        case (md)
            2'd1: begin
                if (xs > ts)      y = ts;
                else if (xs < nt) y = nt;
            end
            2'd2: begin
                // Excess beyond the bound is compressed, not discarded.
                if (xs > ts) begin
                    e = xs - ts;
                    y = ts + (e >>> KNEE_SHIFT);
                    if (y > MAX_S) y = MAX_S;
                end else if (xs < nt) begin
                    e = nt - xs;
                    y = nt - (e >>> KNEE_SHIFT);
                    if (y < -MAX_S) y = -MAX_S;
                end
            end
            2'd3: begin
                if (xs > ts) y = ts;
            end
            default: y = xs;
        endcase
        return y[SAMPLE_W-1:0];
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = prev_module_done ? PROC : IDLE;
            PROC:    state_d = OUTPUT;
            OUTPUT:  state_d = next_module_ready ? IDLE : OUTPUT;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready_for_data = 1'b0;
        done           = 1'b0;
        accept         = 1'b0;
        load_out       = 1'b0;
        case (state_q)
            IDLE: begin
                ready_for_data = 1'b1;
                accept         = prev_module_done;
            end
            PROC:    load_out = 1'b1;
            OUTPUT:  done     = 1'b1;
            default: ;
        endcase
    end

    // Threshold from the frame's config snapshot; a negative result clamps to 0.
    always_comb begin
        t_raw = {5'b00000, {(SAMPLE_W-1){1'b1}}} - (TW'(snap_mag_q) * {4'b0000, STEP});
        thr   = t_raw[TW-1] ? '0 : t_raw[SAMPLE_W-1:0];
    end

    assign eff_mode = snap_en_q ? snap_mode_q : 2'd0;

    always_comb begin
        lane_y   = '0;
        lane_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_y[i*SAMPLE_W +: SAMPLE_W] =
                clip_lane(in_audio_q[i*SAMPLE_W +: SAMPLE_W], thr, eff_mode);
            if (lane_y[i*SAMPLE_W +: SAMPLE_W] != in_audio_q[i*SAMPLE_W +: SAMPLE_W])
                lane_cnt = lane_cnt + CW'(1);
        end
    end

    always_comb begin
        cfg_mag_d   = cfg_mag_q;
        cfg_mode_d  = cfg_mode_q;
        snap_mag_d  = snap_mag_q;
        snap_mode_d = snap_mode_q;
        snap_en_d   = snap_en_q;
        in_audio_d  = in_audio_q;
        in_addr_d   = in_addr_q;
        out_audio_d = out_audio_q;
        out_addr_d  = out_addr_q;
        count_d     = count_q;
        sticky_d    = sticky_q;
        if (set_config) begin
            cfg_mag_d  = magnitude;
            cfg_mode_d = mode;
            sticky_d   = 1'b0;
        end
        // Snapshot uses the pre-update config so same-cycle set_config waits a frame.
        if (accept) begin
            snap_mag_d  = cfg_mag_q;
            snap_mode_d = cfg_mode_q;
            snap_en_d   = en;
            in_audio_d  = audio_in;
            in_addr_d   = address_in;
        end
        if (load_out) begin
            out_audio_d = lane_y;
            out_addr_d  = in_addr_q;
            count_d     = lane_cnt;
            if (lane_cnt != '0) sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_mag_q   <= '0;
            cfg_mode_q  <= 2'd1;
            snap_mag_q  <= '0;
            snap_mode_q <= 2'd1;
            snap_en_q   <= 1'b0;
            in_audio_q  <= '0;
            in_addr_q   <= '0;
            out_audio_q <= '0;
            out_addr_q  <= '0;
            count_q     <= '0;
            sticky_q    <= 1'b0;
        end else begin
            cfg_mag_q   <= cfg_mag_d;
            cfg_mode_q  <= cfg_mode_d;
            snap_mag_q  <= snap_mag_d;
            snap_mode_q <= snap_mode_d;
            snap_en_q   <= snap_en_d;
            in_audio_q  <= in_audio_d;
            in_addr_q   <= in_addr_d;
            out_audio_q <= out_audio_d;
            out_addr_q  <= out_addr_d;
            count_q     <= count_d;
            sticky_q    <= sticky_d;
        end
    end

    assign audio_out   = out_audio_q;
    assign address_out = out_addr_q;
    assign clip_count  = count_q;
    assign clip_sticky = sticky_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clip_distortion_multi.sv
// Directed bench for clip_distortion_multi: hand-computed frames across modes,
// backpressure, config snapshot timing and mid-frame reset.
module tb_clip_distortion_multi;

    localparam int W  = 16;
    localparam int L  = 32;
    localparam int AW = 32;
    localparam int FW = L * W;
    localparam int CW = $clog2(L + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          prev_module_done;
    logic          ready_for_data;
    logic [AW-1:0] address_in;
    logic [FW-1:0] audio_in;
    logic          en;
    logic          set_config;
    logic [3:0]    magnitude;
    logic [1:0]    mode;
    logic          next_module_ready;
    logic          done;
    logic [AW-1:0] address_out;
    logic [FW-1:0] audio_out;
    logic [CW-1:0] clip_count;
    logic          clip_sticky;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    clip_distortion_multi dut (
        .clk               (clk),
        .rst               (rst),
        .prev_module_done  (prev_module_done),
        .ready_for_data    (ready_for_data),
        .address_in        (address_in),
        .audio_in          (audio_in),
        .en                (en),
        .set_config        (set_config),
        .magnitude         (magnitude),
        .mode              (mode),
        .next_module_ready (next_module_ready),
        .done              (done),
        .address_out       (address_out),
        .audio_out         (audio_out),
        .clip_count        (clip_count),
        .clip_sticky       (clip_sticky),
        .dbg_state_o       (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [3:0] m, input logic [1:0] md);
        magnitude  = m;
        mode       = md;
        set_config = 1'b1;
        tick();
        set_config = 1'b0;
    endtask

    task automatic accept(input logic [AW-1:0] a, input logic [FW-1:0] d, input logic e);
        address_in       = a;
        audio_in         = d;
        en               = e;
        prev_module_done = 1'b1;
        tick();
        prev_module_done = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !done; i++) tick();
        check_val({tag, "_done"}, FW'(done), FW'(1'b1));
    endtask

    function automatic logic [FW-1:0] put(input logic [FW-1:0] v, input int i, input logic [W-1:0] s);
        logic [FW-1:0] r;
        r = v;
        r[i*W +: W] = s;
        return r;
    endfunction

    logic [FW-1:0] d, e;

    initial begin
        rst = 1'b1; prev_module_done = 1'b0; address_in = '0; audio_in = '0;
        en = 1'b1; set_config = 1'b0; magnitude = '0; mode = 2'd1;
        next_module_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check_val("rst_ready", FW'(ready_for_data), FW'(1'b1));
        check_val("rst_done", FW'(done), FW'(1'b0));
        check_val("rst_addr", FW'(address_out), '0);
        check_val("rst_audio", audio_out, '0);
        check_val("rst_count", FW'(clip_count), '0);
        check_val("rst_sticky", FW'(clip_sticky), '0);

        // Hard clip, T=0x6EEF; exact done/ready timing
        set_cfg(4'd2, 2'd1);
        d = put(put(put('0, 0, 16'h7000), 1, 16'h8100), 2, 16'h1234);
        e = put(put(put('0, 0, 16'h6EEF), 1, 16'h9111), 2, 16'h1234);
        accept(32'hA0, d, 1'b1);
        check_val("t1_proc_ready", FW'(ready_for_data), FW'(1'b0));
        check_val("t1_proc_done", FW'(done), FW'(1'b0));
        tick();
        check_val("t1_done", FW'(done), FW'(1'b1));
        check_val("t1_audio", audio_out, e);
        check_val("t1_count", FW'(clip_count), FW'(2));
        check_val("t1_sticky", FW'(clip_sticky), FW'(1'b1));
        check_val("t1_addr", FW'(address_out), FW'(32'hA0));
        tick();
        check_val("t1_idle_done", FW'(done), FW'(1'b0));
        check_val("t1_idle_ready", FW'(ready_for_data), FW'(1'b1));
        check_val("t1_idle_hold", audio_out, e);

        // Soft knee: e=0x1000 -> 0x6EEF + 0x0400
        set_cfg(4'd2, 2'd2);
        check_val("t2_sticky_clr", FW'(clip_sticky), FW'(1'b0));
        accept(32'hB0, put('0, 0, 16'h7EEF), 1'b1);
        wait_done("t2");
        check_val("t2_audio", audio_out, put('0, 0, 16'h72EF));
        check_val("t2_count", FW'(clip_count), FW'(1));
        tick();

        // Asymmetric, T=7: negative lane passes through
        set_cfg(4'd15, 2'd3);
        accept(32'hC0, put(put('0, 0, 16'h0100), 1, 16'hF000), 1'b1);
        wait_done("t3");
        check_val("t3_audio", audio_out, put(put('0, 0, 16'h0007), 1, 16'hF000));
        check_val("t3_count", FW'(clip_count), FW'(1));
        tick();

        // en=0 forces bypass on a full-scale frame
        set_cfg(4'd15, 2'd1);
        d = '0;
        for (int i = 0; i < L; i++)
            d = put(d, i, (i % 3 == 0) ? 16'h7FFF : (i % 3 == 1) ? 16'h8000 : 16'h4000 + W'(i));
        accept(32'hDEADBEEF, d, 1'b0);
        wait_done("t4");
        check_val("t4_audio", audio_out, d);
        check_val("t4_count", FW'(clip_count), '0);
        check_val("t4_addr", FW'(address_out), FW'(32'hDEADBEEF));
        check_val("t4_sticky", FW'(clip_sticky), FW'(1'b0));
        tick();

        // Backpressure with a stray prev_module_done during OUTPUT
        set_cfg(4'd2, 2'd1);
        next_module_ready = 1'b0;
        accept(32'hD0, put('0, 0, 16'h7000), 1'b1);
        wait_done("t5");
        for (int k = 0; k < 10; k++) begin
            prev_module_done = (k == 3);
            address_in = 32'h1000 + k;
            audio_in = put('0, 0, 16'h0011);
            tick();
            check_val("t5_hold_done", FW'(done), FW'(1'b1));
            check_val("t5_hold_ready", FW'(ready_for_data), FW'(1'b0));
            check_val("t5_hold_audio", audio_out, put('0, 0, 16'h6EEF));
            check_val("t5_hold_addr", FW'(address_out), FW'(32'hD0));
        end
        prev_module_done = 1'b0;
        next_module_ready = 1'b1;
        tick();
        check_val("t5_release_ready", FW'(ready_for_data), FW'(1'b1));
        check_val("t5_release_done", FW'(done), FW'(1'b0));

        // set_config in the accept cycle applies only to the following frame
        magnitude = 4'd0; mode = 2'd1; set_config = 1'b1;
        accept(32'hE0, put('0, 0, 16'h7000), 1'b1);
        set_config = 1'b0;
        wait_done("t6");
        check_val("t6_old_cfg", audio_out, put('0, 0, 16'h6EEF));
        check_val("t6_count", FW'(clip_count), FW'(1));
        tick();
        accept(32'hF0, put('0, 0, 16'h7000), 1'b1);
        wait_done("t7");
        check_val("t7_new_cfg", audio_out, put('0, 0, 16'h7000));
        check_val("t7_count", FW'(clip_count), '0);
        tick();

        // Asynchronous reset while in PROC
        accept(32'h1234, put('0, 0, 16'h7000), 1'b1);
        rst = 1'b1;
        #1;
        check_val("t8_rst_done", FW'(done), FW'(1'b0));
        check_val("t8_rst_audio", audio_out, '0);
        check_val("t8_rst_sticky", FW'(clip_sticky), FW'(1'b0));
        check_val("t8_rst_ready", FW'(ready_for_data), FW'(1'b1));
        check_val("t8_rst_addr", FW'(address_out), '0);
        #2 rst = 1'b0;
        tick();
        // Default config after reset: hard clip, T=0x7FFF, lower bound 0x8001
        accept(32'h55, put(put('0, 0, 16'h8000), 1, 16'h7FFF), 1'b1);
        wait_done("t9");
        check_val("t9_audio", audio_out, put(put('0, 0, 16'h8001), 1, 16'h7FFF));
        check_val("t9_count", FW'(clip_count), FW'(1));
        check_val("t9_addr", FW'(address_out), FW'(32'h55));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
